count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor.sv | 139 +++++++++++++
 tb/tb_count_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// Sequence monitor for an upstream 4-bit counter: locks after SYNC_LEN correct increments,
// then counts 15->0 wraps and sequence errors seen while locked.
module count_monitor #(
  parameter int unsigned WRAP_W   = 8,
  parameter int unsigned ERR_W    = 4,
  parameter int unsigned SYNC_LEN = 4
) (
  input  logic              pllclk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [3:0]        count_in,
  output logic              locked,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSync  = 2'd1,
    StLock  = 2'd2,
    StFault = 2'd3
  } state_e;

  localparam logic [4:0] SyncLen = 5'(SYNC_LEN);

  state_e            state_q, state_d;
  logic [3:0]        run_q, run_d;
  logic [3:0]        prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic              locked_q, locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic              err_sticky_q, err_sticky_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic       seq_ok;
  logic       match;
  logic       mismatch;
  logic       wrap;
  logic       lock_err;
  logic [4:0] run_inc;

  // Sequence checks only apply on edges where the sample is actually taken (en=1).
  always_comb begin
    seq_ok   = (count_in == (prev_q + 4'd1));
    match    = en & have_prev_q & seq_ok;
    mismatch = en & have_prev_q & ~seq_ok;
    wrap     = match & (prev_q == 4'hf);
    lock_err = (state_q == StLock) & mismatch;
    run_inc  = {1'b0, run_q} + 5'd1;
  end

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    if (!en) begin
      state_d     = StIdle;
      run_d       = 4'd0;
      have_prev_d = 1'b0;
    end else begin
      prev_d      = count_in;
      have_prev_d = 1'b1;
      unique case (state_q)
        StIdle: begin
          state_d = StSync;
          run_d   = 4'd0;
        end
        StSync, StFault: begin
          if (match) begin
            if (run_inc == SyncLen) begin
              state_d = StLock;
              run_d   = 4'd0;
            end else begin
              run_d = run_inc[3:0];
            end
          end else if (mismatch) begin
            run_d = 4'd0;
          end
        end
        StLock: begin
          if (mismatch) state_d = StFault;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Clear is applied first so an event on the same edge lands on a zeroed count.
  always_comb begin
    wrap_cnt_d   = clr ? '0 : wrap_cnt_q;
    err_cnt_d    = clr ? '0 : err_cnt_q;
    err_sticky_d = clr ? 1'b0 : err_sticky_q;
    if (wrap && (state_q == StLock)) wrap_cnt_d = wrap_cnt_d + 1'b1;
    if (lock_err) begin
      err_sticky_d = 1'b1;
      if (err_cnt_d != '1) err_cnt_d = err_cnt_d + 1'b1;
    end
    err_pulse_d = lock_err;
    locked_d    = (state_d == StLock);
  end

  always_ff @(posedge pllclk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      run_q        <= 4'd0;
      prev_q       <= 4'd0;
      have_prev_q  <= 1'b0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      wrap_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      prev_q       <= prev_d;
      have_prev_q  <= have_prev_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      wrap_cnt_q   <= wrap_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign state      = state_q;
  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor with SYNC_LEN=4, WRAP_W=8, ERR_W=4.
module tb_count_monitor;

  logic       pllclk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [3:0] count_in;
  logic       locked;
  logic       err_pulse;
  logic       err_sticky;
  logic [7:0] wrap_cnt;
  logic [3:0] err_cnt;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  logic [3:0] cur = 4'd0;

  count_monitor #(
    .WRAP_W  (8),
    .ERR_W   (4),
    .SYNC_LEN(4)
  ) dut (
    .pllclk    (pllclk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .count_in  (count_in),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky),
    .wrap_cnt  (wrap_cnt),
    .err_cnt   (err_cnt),
    .state     (state)
  );

  initial pllclk = 1'b0;
  always #5 pllclk = ~pllclk;

  // Drive one sample, take one edge, settle 1 time unit past it.
  task automatic step(input logic [3:0] v, input logic c);
    count_in = v;
    clr      = c;
    cur      = v;
    @(posedge pllclk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; clr = 1'b0; count_in = 4'd0;
    #2;
    checks++;
    if ({state, locked, err_pulse, err_sticky} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: state=%0d locked=%b pulse=%b sticky=%b required 0", state,
               locked, err_pulse, err_sticky);
    end
    checks++;
    if (wrap_cnt !== 8'd0 || err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_counts: wrap=%0d err=%0d required 0/0", wrap_cnt, err_cnt);
    end
    @(posedge pllclk); #1;
    rst = 1'b0;
  endtask

  task automatic test_lock;
    en = 1'b1;
    step(4'd0, 1'b0);
    checks++;
    if (state !== 2'd1) begin
      errors++; $display("FAIL sync_entry: state=%0d required 1", state);
    end
    for (int i = 1; i <= 3; i++) begin
      step(4'(i), 1'b0);
      checks++;
      if (locked !== 1'b0) begin
        errors++; $display("FAIL early_lock: edge %0d locked=%b required 0", i + 1, locked);
      end
    end
    step(4'd4, 1'b0);
    checks++;
    if (locked !== 1'b1 || state !== 2'd2 || err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL lock: locked=%b state=%0d err=%0d required 1/2/0", locked, state, err_cnt);
    end
  endtask

  task automatic test_error;
    step(4'd5, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL lock_hold: locked=%b pulse=%b required 1/0", locked, err_pulse);
    end
    step(4'd7, 1'b0);
    checks++;
    if (err_pulse !== 1'b1 || err_cnt !== 4'd1 || err_sticky !== 1'b1 || locked !== 1'b0 ||
        state !== 2'd3) begin
      errors++;
      $display("FAIL lock_err: pulse=%b err=%0d sticky=%b locked=%b state=%0d required 1/1/1/0/3",
               err_pulse, err_cnt, err_sticky, locked, state);
    end
    step(4'd8, 1'b0);
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++; $display("FAIL pulse_width: pulse=%b required 0", err_pulse);
    end
    step(4'd9, 1'b0);
    step(4'd10, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL relock_early: locked=%b required 0", locked);
    end
    step(4'd11, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_sticky !== 1'b1 || err_cnt !== 4'd1) begin
      errors++;
      $display("FAIL relock: locked=%b sticky=%b err=%0d required 1/1/1", locked, err_sticky,
               err_cnt);
    end
  endtask

  task automatic test_wrap;
    step(4'd12, 1'b1);
    checks++;
    if (state !== 2'd2 || err_cnt !== 4'd0 || err_sticky !== 1'b0 || wrap_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr: state=%0d err=%0d sticky=%b wrap=%0d required 2/0/0/0", state, err_cnt,
               err_sticky, wrap_cnt);
    end
    for (int i = 0; i < 48; i++) step(cur + 4'd1, 1'b0);
    checks++;
    if (wrap_cnt !== 8'd3 || err_cnt !== 4'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL wrap3: wrap=%0d err=%0d locked=%b required 3/0/1", wrap_cnt, err_cnt, locked);
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 20; i++) begin
      step(cur + 4'd2, 1'b0);
      for (int k = 0; k < 4; k++) step(cur + 4'd1, 1'b0);
      if (i == 14) begin
        checks++;
        if (err_cnt !== 4'd15) begin
          errors++; $display("FAIL err15: err=%0d required 15", err_cnt);
        end
      end
    end
    checks++;
    if (err_cnt !== 4'd15 || err_sticky !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL saturate: err=%0d sticky=%b locked=%b required 15/1/1", err_cnt, err_sticky,
               locked);
    end
  endtask

  task automatic test_clr_mismatch;
    int w;
    w = (cur == 4'd15) ? 1 : 0;
    step(cur + 4'd1, 1'b1);
    while (w < 5) begin
      if (cur == 4'd15) w++;
      step(cur + 4'd1, 1'b0);
    end
    checks++;
    if (wrap_cnt !== 8'd5) begin
      errors++; $display("FAIL wrap5: wrap=%0d required 5", wrap_cnt);
    end
    step(4'd10, 1'b1);
    checks++;
    if (wrap_cnt !== 8'd0 || err_cnt !== 4'd1 || err_sticky !== 1'b1 || err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL clr_err: wrap=%0d err=%0d sticky=%b pulse=%b required 0/1/1/1", wrap_cnt,
               err_cnt, err_sticky, err_pulse);
    end
  endtask

  task automatic test_clr_wrap;
    for (int v = 11; v <= 15; v++) step(4'(v), 1'b0);
    step(4'd0, 1'b1);
    checks++;
    if (wrap_cnt !== 8'd1 || err_cnt !== 4'd0 || err_sticky !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL clr_wrap: wrap=%0d err=%0d sticky=%b locked=%b required 1/0/0/1", wrap_cnt,
               err_cnt, err_sticky, locked);
    end
    // Wrap taken while in FAULT must not count.
    step(4'd14, 1'b0);
    step(4'd15, 1'b0);
    step(4'd0, 1'b0);
    checks++;
    if (wrap_cnt !== 8'd1 || state !== 2'd3 || err_cnt !== 4'd1) begin
      errors++;
      $display("FAIL fault_wrap: wrap=%0d state=%0d err=%0d required 1/3/1", wrap_cnt, state,
               err_cnt);
    end
    step(4'd1, 1'b0);
    step(4'd2, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL fault_relock: locked=%b required 1", locked);
    end
  endtask

  task automatic test_en_and_async_reset;
    int w;
    step(cur + 4'd1, 1'b1);
    w = (cur == 4'd0) ? 1 : 0;
    while (w < 2) begin
      if (cur == 4'd15) w++;
      step(cur + 4'd1, 1'b0);
    end
    en = 1'b0;
    step(4'd9, 1'b0);
    checks++;
    if (state !== 2'd0 || locked !== 1'b0 || wrap_cnt !== 8'd2 || err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL en_drop: state=%0d locked=%b wrap=%0d err=%0d required 0/0/2/0", state,
               locked, wrap_cnt, err_cnt);
    end
    en = 1'b1;
    for (int v = 1; v <= 5; v++) step(4'(v), 1'b0);
    checks++;
    if (locked !== 1'b1 || wrap_cnt !== 8'd2) begin
      errors++; $display("FAIL en_relock: locked=%b wrap=%0d required 1/2", locked, wrap_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({state, locked, err_pulse, err_sticky} !== 5'b0 || wrap_cnt !== 8'd0 ||
        err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL async_rst: state=%0d locked=%b sticky=%b wrap=%0d err=%0d required all 0",
               state, locked, err_sticky, wrap_cnt, err_cnt);
    end
    @(posedge pllclk); #1;
    rst = 1'b0;
    for (int v = 6; v <= 9; v++) begin
      step(4'(v), 1'b0);
      checks++;
      if (locked !== 1'b0) begin
        errors++; $display("FAIL post_rst_early: edge %0d locked=%b required 0", v - 5, locked);
      end
    end
    step(4'd10, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL post_rst_lock: locked=%b required 1", locked);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_error();
    test_wrap();
    test_saturate();
    test_clr_mismatch();
    test_clr_wrap();
    test_en_and_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
